// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder controller: one shared 4-bit slice walks the operands nibble by
// nibble, LS first, with the carry held in a register between steps.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSTEPS = WIDTH / 4;
    localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The shared 4-bit adder slice: returns {carry, sum nibble}.
    function automatic logic [4:0] four_bit_add(input logic [3:0] x,
                                                input logic [3:0] y,
                                                input logic       ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [SW-1:0]     step_q, step_d;
    logic              carry_q, carry_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SW+1:0]     idx_s;
    logic [4:0]        slice_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        step_d      = step_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        idx_s       = {step_q, 2'b00};
        slice_s     = four_bit_add(a_q[idx_s +: 4], b_q[idx_s +: 4], carry_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    a_d         = a;
                    b_d         = b;
                    carry_d     = carry_in;
                    sum_d       = {WIDTH{1'b0}};
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    step_d      = {SW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[idx_s +: 4] = slice_s[3:0];
                carry_d           = slice_s[4];
                if (step_q == LAST_STEP) begin
                    // slice_s[3] is the final sum MSB written on this edge
                    carry_out_d = slice_s[4];
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (slice_s[3] != a_q[WIDTH-1]);
                    step_d      = {SW{1'b0}};
                    state_d     = S_DONE;
                end else begin
                    step_d  = step_q + SW'(1);
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            step_q      <= {SW{1'b0}};
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            step_q      <= step_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed corner cases plus
// random additions compared against plain 33-bit arithmetic.
module tb_nibble_serial_add_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         carry_in;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] sum;

    int tests_run = 0;
    int tests_failed = 0;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word addition, independent of any nibble stepping.
    function automatic logic [34:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {1'b0, ovf, full};
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [34:0] r;
        r = ref_add(x, y, ci);
        check_eq({tag, "_sum"}, 64'(sum), 64'(r[W-1:0]));
        check_eq({tag, "_cout"}, 64'(carry_out), 64'(r[W]));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(r[W+1]));
    endtask

    // One full operation: start for one cycle, scramble inputs, time busy/done.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int n;
        @(negedge clk);
        start = 1'b1; a = x; b = y; carry_in = ci;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; carry_in = 1'($urandom);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_len"}, 64'(n), 64'd8);
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_result(tag, x, y, ci);
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n_done, last_cyc, cyc, k;
        logic [W-1:0] qa[$], qb[$];
        logic         qc[$];
        logic [W-1:0] ea, eb;
        logic         ec;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(carry_out), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;

        run_op("t1", 32'h0000_0001, 32'h0000_0001, 1'b0);
        check_eq("t1_abs", 64'(sum), 64'h2);
        run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check_eq("t2_abs_cout", 64'(carry_out), 64'd1);
        run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_eq("t3a_abs_ovf", 64'(overflow), 64'd1);
        run_op("t3b", 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Start ignored during RUN; operands changed after acceptance.
        @(negedge clk);
        start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; carry_in = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check_eq("t4_sum", 64'(sum), 64'h2345_6789);
            end
        end
        check_eq("t4_done_count", 64'(n_done), 64'd1);

        // Reset in the 4th RUN cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0F0F_0F0F; carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_done", 64'(done), 64'd0);
        check_eq("t5_sum", 64'(sum), 64'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check_eq("t5_stays_idle", 64'(n_done), 64'd0);
        run_op("t5b", 32'h0000_0010, 32'h0000_0020, 1'b0);
        check_eq("t5b_abs", 64'(sum), 64'h30);

        // Continuous start: back-to-back operations, 9 cycles apart.
        @(negedge clk);
        start = 1'b1;
        a = $urandom; b = $urandom; carry_in = 1'($urandom);
        qa.push_back(a); qb.push_back(b); qc.push_back(carry_in);
        n_done = 0; last_cyc = 0; cyc = 0;
        while (n_done < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                check_result("t6", ea, eb, ec);
                if (n_done > 0) check_eq("t6_spacing", 64'(cyc - last_cyc), 64'd9);
                last_cyc = cyc;
                n_done++;
                if (n_done < 5) begin
                    a = n_done[0] ? 32'h8000_0000 | W'($urandom) : W'($urandom) & 32'h7FFF_FFFF;
                    b = n_done[0] ? ~a : W'($urandom);
                    carry_in = n_done[0];
                    qa.push_back(a); qb.push_back(b); qc.push_back(carry_in);
                end else begin
                    start = 1'b0;
                end
            end else if (cyc > 1) begin
                check_eq("t6_busy", 64'(busy), 64'd1);
            end
        end
        check_eq("t6_done_count", 64'(n_done), 64'd5);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random operations.
        for (int i = 0; i < 25; i++) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0: run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));
                1: run_op("rnd_ones", 32'hFFFF_FFFF, W'($urandom), 1'($urandom));
                2: run_op("rnd_msb", 32'h8000_0000 | W'($urandom), 32'h8000_0000 | W'($urandom), 1'b0);
                default: run_op("rnd_pos", W'($urandom) & 32'h7FFF_FFFF, W'($urandom) & 32'h7FFF_FFFF, 1'b1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
